// File: rtl/alu_rf_pkg.sv
// alu_rf_pkg: opcode encodings, FSM state type and flag bit positions shared
// by the accumulator ALU and its multiplier.
package alu_rf_pkg;

    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_LOAD = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_OUT  = 4'h7;
    localparam logic [3:0] ALU_CLR  = 4'h8;
    localparam logic [3:0] ALU_SHL  = 4'h9;
    localparam logic [3:0] ALU_SHR  = 4'hA;
    localparam logic [3:0] ALU_MOVA = 4'hB;
    localparam logic [3:0] ALU_MUL  = 4'hC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/alu_rf_mul.sv
// alu_rf_mul: sequential shift-add multiplier, one partial product per clock.
// o_product presents the value the product register takes at the next edge,
// so on the o_done cycle it already holds the full product and the caller
// can capture it on the same edge the last partial product is added.
module alu_rf_mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      a_reset_n,
    input  logic                      i_start,
    input  logic [DATA_WIDTH-1:0]     i_a,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic                      o_done,
    output logic [2*DATA_WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;

    assign o_product = r_prod + (r_b[0] ? r_a : '0);
    assign o_done    = r_busy && (r_cnt == CNT_W'(DATA_WIDTH - 1));

    // Snapshot operands on start, then add one shifted multiplicand per cycle
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= {{DATA_WIDTH{1'b0}}, i_a};
            r_b    <= i_b;
            r_prod <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_prod <= o_product;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_rf.sv
// alu_rf: accumulator ALU with a small register file, valid/ready command
// port and Z/C/V flags. Define ALU_RF_MUL_EN to enable the multi-cycle MUL
// opcode; without it MUL behaves as NOP and the ALU is always ready.
module alu_rf
    import alu_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    localparam int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic [SEL_W-1:0]      reg_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  busy
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_out_valid;
    logic [NUM_FLAGS-1:0]  r_flags;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_opnd;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [NUM_FLAGS-1:0]  w_flags_nxt;
    logic                  w_c;
    logic                  w_v;
    logic                  w_upd;

`ifdef ALU_RF_MUL_EN
    alu_state_t              r_state;
    logic                    r_in_ready;
    logic                    w_mul_start;
    logic                    w_mul_done;
    logic [2*DATA_WIDTH-1:0] w_mul_product;

    assign in_ready    = r_in_ready;
    assign w_mul_start = w_accept && (opcode == ALU_MUL);

    alu_rf_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .i_start   (w_mul_start),
        .i_a       (r_acc),
        .i_b       (w_opnd),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign in_ready = 1'b1;
`endif

    assign busy      = !in_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_opnd    = r_regs[reg_sel];
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_opnd};
    assign w_diff    = {1'b0, r_acc} - {1'b0, w_opnd};
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign flag_z    = r_flags[FLAG_Z];
    assign flag_c    = r_flags[FLAG_C];
    assign flag_v    = r_flags[FLAG_V];

    // Next accumulator value and flags for the single-cycle opcodes
    always_comb begin
        w_acc_nxt   = r_acc;
        w_flags_nxt = r_flags;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_upd       = 1'b0;
        case (opcode)
            ALU_ADD: begin
                w_acc_nxt = w_sum[MSB:0];
                w_c       = w_sum[DATA_WIDTH];
                w_v       = (r_acc[MSB] == w_opnd[MSB]) && (w_sum[MSB] != r_acc[MSB]);
                w_upd     = 1'b1;
            end
            ALU_SUB: begin
                w_acc_nxt = w_diff[MSB:0];
                w_c       = w_diff[DATA_WIDTH];
                w_v       = (r_acc[MSB] != w_opnd[MSB]) && (w_diff[MSB] != r_acc[MSB]);
                w_upd     = 1'b1;
            end
            ALU_AND: begin
                w_acc_nxt = r_acc & w_opnd;
                w_upd     = 1'b1;
            end
            ALU_OR: begin
                w_acc_nxt = r_acc | w_opnd;
                w_upd     = 1'b1;
            end
            ALU_XOR: begin
                w_acc_nxt = r_acc ^ w_opnd;
                w_upd     = 1'b1;
            end
            ALU_SHL: begin
                w_acc_nxt = r_acc << 1;
                w_c       = r_acc[MSB];
                w_upd     = 1'b1;
            end
            ALU_SHR: begin
                w_acc_nxt = r_acc >> 1;
                w_c       = r_acc[0];
                w_upd     = 1'b1;
            end
            ALU_CLR: begin
                w_acc_nxt = '0;
            end
            default: begin
            end
        endcase
        if (w_upd) begin
            w_flags_nxt[FLAG_Z] = (w_acc_nxt == '0);
            w_flags_nxt[FLAG_C] = w_c;
            w_flags_nxt[FLAG_V] = w_v;
        end
        // CLR zeroes every flag, including Z, even though acc becomes zero
        if (opcode == ALU_CLR) begin
            w_flags_nxt = '0;
        end
    end

    // Command execution, register file, output port and IDLE/MUL control
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_acc       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_flags     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
`ifdef ALU_RF_MUL_EN
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
`endif
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc   <= w_acc_nxt;
                r_flags <= w_flags_nxt;
                case (opcode)
                    ALU_LOAD: r_regs[reg_sel] <= data_in;
                    ALU_MOVA: r_regs[reg_sel] <= r_acc;
                    ALU_OUT: begin
                        r_data_out  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
`ifdef ALU_RF_MUL_EN
                if (opcode == ALU_MUL) begin
                    r_state    <= ST_MUL;
                    r_in_ready <= 1'b0;
                end
`endif
            end
`ifdef ALU_RF_MUL_EN
            else if ((r_state == ST_MUL) && w_mul_done) begin
                r_acc               <= w_mul_product[MSB:0];
                r_flags[FLAG_Z]     <= (w_mul_product[MSB:0] == '0);
                r_flags[FLAG_C]     <= |w_mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
                r_flags[FLAG_V]     <= 1'b0;
                r_state             <= ST_IDLE;
                r_in_ready          <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_rf.sv
// tb_alu_rf: directed bench for alu_rf (DATA_WIDTH=8, NUM_REGS=4). Expected
// OUT results are queued when the OUT command is issued and compared when
// out_valid appears; flags and handshake are checked inline.
module tb_alu_rf;
    import alu_rf_pkg::*;

`ifdef ALU_RF_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       a_reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'h0;
    logic [1:0] reg_sel = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       out_valid;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];

    alu_rf #(
        .DATA_WIDTH (8),
        .NUM_REGS   (4)
    ) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .reg_sel   (reg_sel),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic c, input logic v);
        chk(tag, {29'd0, flag_v, flag_c, flag_z}, {29'd0, v, c, z});
    endtask

    // Present a command, wait (bounded) for ready, let it be accepted, drop valid.
    task automatic cmd(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        opcode   = op;
        reg_sel  = sel;
        data_in  = d;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = ALU_NOP;
    endtask

    task automatic do_out(input logic [7:0] exp);
        sb.push_back(exp);
        cmd(ALU_OUT, 2'd0, 8'h00);
    endtask

    // Scoreboard: every out_valid must match the oldest queued expectation
    always @(negedge clk) begin
        logic [7:0] e;
        if (a_reset_n && out_valid) begin
            chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, e});
            end
        end
    end

    initial begin
        int cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        a_reset_n = 1'b1;
        @(posedge clk);
        #1;

        // OUT right after reset: one-cycle pulse carrying 0
        do_out(8'h00);
        chk("out_pulse_hi", {31'd0, out_valid}, 32'd1);
        chk_flags("out0_flags", 1'b0, 1'b0, 1'b0);
        chk("out0_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("out_pulse_lo", {31'd0, out_valid}, 32'd0);
        chk("data_out_hold", {24'd0, data_out}, 32'h00);

        // 0x0F + 0x0F
        cmd(ALU_LOAD, 2'd0, 8'h0F);
        cmd(ALU_ADD,  2'd0, 8'h00);
        cmd(ALU_ADD,  2'd0, 8'h00);
        chk_flags("add1e_flags", 1'b0, 1'b0, 1'b0);
        do_out(8'h1E);

        // Signed overflow into 0x80, then 0x80 + 0x80 wraps to zero
        cmd(ALU_CLR,  2'd0, 8'h00);
        cmd(ALU_LOAD, 2'd0, 8'h7F);
        cmd(ALU_ADD,  2'd0, 8'h00);
        cmd(ALU_LOAD, 2'd1, 8'h01);
        cmd(ALU_ADD,  2'd1, 8'h00);
        chk_flags("ovf80_flags", 1'b0, 1'b0, 1'b1);
        do_out(8'h80);
        cmd(ALU_LOAD, 2'd2, 8'h80);
        cmd(ALU_ADD,  2'd2, 8'h00);
        chk_flags("wrap0_flags", 1'b1, 1'b1, 1'b1);
        do_out(8'h00);

        // CLR clears flags even though acc is zero
        cmd(ALU_CLR, 2'd0, 8'h00);
        chk_flags("clr_flags", 1'b0, 1'b0, 1'b0);

        // Borrow on 5 - 15, then logical shift right
        cmd(ALU_LOAD, 2'd0, 8'h05);
        cmd(ALU_ADD,  2'd0, 8'h00);
        cmd(ALU_LOAD, 2'd1, 8'h0F);
        cmd(ALU_SUB,  2'd1, 8'h00);
        chk_flags("sub_borrow_flags", 1'b0, 1'b1, 1'b0);
        do_out(8'hF6);
        cmd(ALU_SHR, 2'd0, 8'h00);
        chk_flags("shr_flags", 1'b0, 1'b0, 1'b0);
        do_out(8'h7B);

        // Shift left: 0x7B -> 0xF6 (C=0) -> 0xEC (C=1)
        cmd(ALU_SHL, 2'd0, 8'h00);
        chk_flags("shl1_flags", 1'b0, 1'b0, 1'b0);
        cmd(ALU_SHL, 2'd0, 8'h00);
        chk_flags("shl2_flags", 1'b0, 1'b1, 1'b0);

        // Logic ops clear C; MOVA copies acc into r3
        cmd(ALU_AND, 2'd1, 8'h00);
        chk_flags("and_flags", 1'b0, 1'b0, 1'b0);
        cmd(ALU_XOR, 2'd1, 8'h00);
        cmd(ALU_OR,  2'd2, 8'h00);
        do_out(8'h83);
        cmd(ALU_MOVA, 2'd3, 8'h00);
        cmd(ALU_CLR,  2'd0, 8'h00);
        cmd(ALU_ADD,  2'd3, 8'h00);
        do_out(8'h83);

        // Equal operands: zero result, no borrow; reserved opcode keeps flags
        cmd(ALU_SUB, 2'd3, 8'h00);
        chk_flags("sub_eq_flags", 1'b1, 1'b0, 1'b0);
        cmd(4'hD, 2'd3, 8'h00);
        chk_flags("reserved_flags", 1'b1, 1'b0, 1'b0);
        do_out(8'h00);

        // MUL 0x0F * 0x12 with an ADD held behind it
        cmd(ALU_CLR,  2'd0, 8'h00);
        cmd(ALU_LOAD, 2'd0, 8'h0F);
        cmd(ALU_ADD,  2'd0, 8'h00);
        cmd(ALU_LOAD, 2'd3, 8'h12);
        cmd(ALU_MUL,  2'd3, 8'h00);
        in_valid = 1'b1;
        opcode   = ALU_ADD;
        reg_sel  = 2'd0;
        cnt      = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("mul_busy_cycles", cnt, MUL_ON ? 32'd8 : 32'd0);
        chk_flags("mul_flags", 1'b0, MUL_ON, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = ALU_NOP;
        chk("post_mul_ready", {31'd0, in_ready}, 32'd1);
        do_out(MUL_ON ? 8'h1D : 8'h1E);

        // Reset asserted three cycles into a MUL
        cmd(ALU_LOAD, 2'd1, 8'h03);
        cmd(ALU_MUL,  2'd1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_mul_busy", {31'd0, busy}, {31'd0, MUL_ON});
        #2;
        a_reset_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_data_out", {24'd0, data_out}, 32'd0);
        chk_flags("abort_flags", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a_reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_ready_late", {31'd0, in_ready}, 32'd1);
        cmd(ALU_ADD, 2'd1, 8'h00);
        chk_flags("abort_regs_zero", 1'b1, 1'b0, 1'b0);
        do_out(8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
